// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO drained by a baud-paced 8N1 serializer, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_buffered #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [7:0]               wdata_i,
    input  logic                     clr_ovf_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o,
    output logic                     tx_o
);

    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(CPB);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]       mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             ovf_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic tick;
    logic [7:0] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = we_i && !full;
    assign pop   = (state_q == S_IDLE) && !empty;
    assign tick  = (cnt_q == CNT_LAST);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign full_o  = full;
    assign empty_o = empty;
    assign busy_o  = !empty || (state_q != S_IDLE);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign ovf_o   = ovf_q;
    assign tx_o    = tx_q;

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // A dropped write outranks a simultaneous clear.
            if (we_i && full) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE:   tx_q <= 1'b1;
                S_START:  tx_q <= 1'b0;
                S_DATA:   tx_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
                S_PARITY: tx_q <= parity_q;
`endif
                default:  tx_q <= 1'b1;
            endcase

            if (state_q == S_IDLE) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q  <= head;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^head;
`endif
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: queue/timeline model compared every cycle,
// a mid-bit line decoder, and directed literal checks. Baud scaled to 16 clocks per bit.
module tb_uart_tx_buffered;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 3125000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int NBC = NB * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we_i = 1'b0;
    logic [7:0] wdata_i = 8'h00;
    logic       clr_ovf_i = 1'b0;
    logic       full_o, empty_o, busy_o, ovf_o, tx_o;
    logic [4:0] level_o;

    uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .we_i(we_i), .wdata_i(wdata_i), .clr_ovf_i(clr_ovf_i),
        .full_o(full_o), .empty_o(empty_o), .busy_o(busy_o), .level_o(level_o),
        .ovf_o(ovf_o), .tx_o(tx_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: byte queue plus the edge at which the frame now on the line was popped.
    logic [7:0] mq[$];
    int         cyc = 0;
    int         p_edge = -1000000;
    logic [7:0] cur = 8'h00;
    bit         ovf_m = 0;

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int  e;
        int  sz;
        bit  idle;
        if (!rst_n) begin
            mq.delete();
            ovf_m  = 0;
            p_edge = -1000000;
        end else begin
            e    = cyc + 1;
            sz   = mq.size();
            idle = ((e - 1) - p_edge) >= NBC;
            if (idle && sz > 0) begin
                cur    = mq.pop_front();
                p_edge = e;
            end
            if (we_i && sz == DEPTH) ovf_m = 1;
            else if (clr_ovf_i) ovf_m = 0;
            if (we_i && sz < DEPTH) mq.push_back(wdata_i);
            cyc = e;
        end
    end

    always @(negedge clk) begin : compare
        int   k;
        logic exp_tx;
        if (chk_en) begin
            k      = cyc - p_edge - 1;
            exp_tx = (k >= 0 && k < NBC) ? frame_bit(cur, k / CPB) : 1'b1;
            chk("tx", tx_o, exp_tx);
            chk("level", level_o, mq.size());
            chk("empty", empty_o, mq.size() == 0);
            chk("full", full_o, mq.size() == DEPTH);
            chk("busy", busy_o, (mq.size() > 0) || ((cyc - p_edge) < NBC));
            chk("ovf", ovf_o, ovf_m);
        end
    end

    // Line decoder sampling each bit at its middle.
    bit         rx_act = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_b = 8'h00;
    logic       rx_prev = 1'b1;
    logic [7:0] rxq[$];

    always @(negedge clk) begin : decoder
        int idx;
        if (!rst_n) begin
            rx_act  = 0;
            rx_prev = 1'b1;
        end else begin
            if (rx_act) begin
                rx_cnt++;
                if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && ((rx_cnt - CPB/2) % CPB) == 0) begin
                    idx = (rx_cnt - CPB/2) / CPB - 1;
                    rx_b[idx] = tx_o;
                end
                if (rx_cnt == (NB-1)*CPB + CPB/2) begin
                    rxq.push_back(rx_b);
                    rx_act = 0;
                end
            end else if (rx_prev && !tx_o) begin
                rx_act = 1;
                rx_cnt = 0;
            end
            rx_prev = tx_o;
        end
    end

    task automatic drive(input bit we, input logic [7:0] d, input bit clr);
        we_i = we;
        wdata_i = d;
        clr_ovf_i = clr;
        @(negedge clk);
        we_i = 1'b0;
        clr_ovf_i = 1'b0;
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) drive(0, 8'h00, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int         w;
        logic [9:0] pat55;
        logic [7:0] exp2 [3];
        exp2[0] = 8'h41; exp2[1] = 8'h42; exp2[2] = 8'h43;
        pat55 = 10'b1010101010;

        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_tx", tx_o, 1);
        chk("rst_level", level_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", ovf_o, 0);
        rst_n = 1'b1;
        repeat (3) drive(0, 8'h00, 0);

        // 1: single byte 0x55, latency, mid-bit pattern, busy release
        drive(1, 8'h55, 0);
        w = cyc;
        chk("t1_busy_after_write", busy_o, 1);
        wait_edge(w + 1);
        chk("t1_tx_before_fall", tx_o, 1);
        wait_edge(w + 2);
        chk("t1_tx_fall", tx_o, 0);
        for (int k = 0; k < 10; k++) begin
            wait_edge(w + 2 + k*CPB + CPB/2);
            chk("t1_midbit", tx_o, pat55[k]);
        end
        wait_edge(w + NBC);
        chk("t1_busy_last", busy_o, 1);
        wait_edge(w + NBC + 1);
        chk("t1_busy_low", busy_o, 0);
        wait_edge(w + NBC + 20);

        // 2: three back-to-back bytes, level trace and one-clock gaps
        rxq.delete();
        drive(1, 8'h41, 0);
        w = cyc;
        drive(1, 8'h42, 0);
        drive(1, 8'h43, 0);
        chk("t2_level_peak", level_o, 2);
        wait_edge(w + 1 + NBC);
        chk("t2_level_before_pop2", level_o, 2);
        chk("t2_tx_stop_end", tx_o, 1);
        wait_edge(w + 2 + NBC);
        chk("t2_level_after_pop2", level_o, 1);
        chk("t2_tx_gap", tx_o, 1);
        wait_edge(w + 3 + NBC);
        chk("t2_tx_start2", tx_o, 0);
        wait_edge(w + 3 + 2*NBC);
        chk("t2_level_after_pop3", level_o, 0);
        wait_edge(w + 3*(NBC + 1) + 20);
        chk("t2_rx_count", rxq.size(), 3);
        for (int i = 0; i < 3 && i < rxq.size(); i++) chk("t2_rx_byte", rxq[i], exp2[i]);

        // 3 and 4: fill to full, overflow handling, drop during a pop
        rxq.delete();
        drive(1, 8'h10, 0);
        w = cyc;
        for (int i = 1; i <= 16; i++) drive(1, 8'h10 + 8'(i), 0);
        chk("t3_full", full_o, 1);
        chk("t3_level16", level_o, 16);
        chk("t3_ovf_clear", ovf_o, 0);
        drive(1, 8'hEE, 1);
        chk("t3_ovf_set_wins", ovf_o, 1);
        chk("t3_level_kept", level_o, 16);
        drive(0, 8'h00, 1);
        chk("t3_ovf_cleared", ovf_o, 0);
        wait_edge(w + 1 + NBC);
        chk("t4_level_pre", level_o, 16);
        chk("t4_full_pre", full_o, 1);
        drive(1, 8'hDD, 0);
        chk("t4_level_15", level_o, 15);
        chk("t4_ovf", ovf_o, 1);
        chk("t4_not_full", full_o, 0);
        drive(0, 8'h00, 1);
        wait_edge(w + 17*(NBC + 1) + 20);
        chk("t3_rx_count", rxq.size(), 17);
        for (int i = 0; i < 17 && i < rxq.size(); i++) chk("t3_rx_byte", rxq[i], 8'h10 + 8'(i));

        // 5: reset in the middle of a data bit
        drive(1, 8'hA3, 0);
        w = cyc;
        wait_edge(w + 2 + 3*CPB + 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", tx_o, 1);
        chk("t5_rst_level", level_o, 0);
        chk("t5_rst_busy", busy_o, 0);
        @(negedge clk);
        drive(0, 8'h00, 0);
        rst_n = 1'b1;
        repeat (2) drive(0, 8'h00, 0);
        rxq.delete();
        drive(1, 8'h0F, 0);
        w = cyc;
        wait_edge(w + NBC + 20);
        chk("t5_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("t5_rx_byte", rxq[0], 8'h0F);

`ifdef UART_TX_PARITY_EN
        // 6: parity bit and 11-bit frame length
        drive(1, 8'h07, 0);
        w = cyc;
        wait_edge(w + 2 + 9*CPB + CPB/2);
        chk("t6_parity_07", tx_o, 1);
        wait_edge(w + NBC);
        chk("t6_busy_last", busy_o, 1);
        wait_edge(w + NBC + 1);
        chk("t6_busy_low", busy_o, 0);
        wait_edge(w + NBC + 10);
        drive(1, 8'h03, 0);
        w = cyc;
        wait_edge(w + 2 + 9*CPB + CPB/2);
        chk("t6_parity_03", tx_o, 0);
        wait_edge(w + NBC + 10);
`endif

        repeat (5) drive(0, 8'h00, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
